// File: rtl/rs_issue_arbiter.sv
// Round-robin issue arbiter: grants one reservation station per cycle into a one-entry FU issue
// register and tracks in-flight ops. Optional stall counter under `RS_ARB_STALL_CNT_EN`.
module rs_issue_arbiter #(
  parameter int unsigned NUM_RS       = 4,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned OP_W         = 4,
  parameter int unsigned ROB_W        = 3,
  parameter int unsigned MAX_INFLIGHT = 2,
  localparam int unsigned SRC_W       = $clog2(NUM_RS),
  localparam int unsigned CNT_W       = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [NUM_RS-1:0]        rs_valid_in,
  input  logic [NUM_RS*DATA_W-1:0] rs_rval1_in,
  input  logic [NUM_RS*DATA_W-1:0] rs_rval2_in,
  input  logic [NUM_RS*OP_W-1:0]   rs_opcode_in,
  input  logic [NUM_RS*ROB_W-1:0]  rs_rob_idx_in,
  output logic [NUM_RS-1:0]        rs_fu_busy_out,
  input  logic                     fu_ready_in,
  input  logic                     fu_done_in,
  input  logic                     flush_in,
  output logic                     fu_valid_out,
  output logic [DATA_W-1:0]        fu_rval1_out,
  output logic [DATA_W-1:0]        fu_rval2_out,
  output logic [OP_W-1:0]          fu_opcode_out,
  output logic [ROB_W-1:0]         fu_rob_idx_out,
  output logic [SRC_W-1:0]         fu_src_out,
  output logic [CNT_W-1:0]         inflight_out
`ifdef RS_ARB_STALL_CNT_EN
  ,
  output logic [15:0]              stall_cycles_out
`endif
);

  logic [SRC_W-1:0]  r_ptr;
  logic [CNT_W-1:0]  r_occ;
  logic              r_fu_valid;
  logic [DATA_W-1:0] r_rval1;
  logic [DATA_W-1:0] r_rval2;
  logic [OP_W-1:0]   r_opcode;
  logic [ROB_W-1:0]  r_rob_idx;
  logic [SRC_W-1:0]  r_src;

  logic              w_can_grant;
  logic              w_any;
  logic              w_grant;
  logic              w_dec;
  logic [SRC_W-1:0]  w_g;
  logic [SRC_W-1:0]  w_ptr_nxt;
  logic [NUM_RS-1:0] w_busy;
  logic [DATA_W-1:0] w_rval1;
  logic [DATA_W-1:0] w_rval2;
  logic [OP_W-1:0]   w_opcode;
  logic [ROB_W-1:0]  w_rob_idx;

  // Station index k positions above base, modulo NUM_RS (base and k are both below NUM_RS).
  function automatic logic [SRC_W-1:0] rr_idx(input logic [SRC_W-1:0] base,
                                               input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= NUM_RS) s = s - NUM_RS;
    return SRC_W'(s);
  endfunction

  // Capacity uses the registered occupancy, so a done in this cycle frees a slot only next cycle.
  assign w_can_grant = !rst_in && !flush_in && (32'(r_occ) < MAX_INFLIGHT) &&
                       (!r_fu_valid || fu_ready_in);

  always_comb begin
    w_any = 1'b0;
    w_g   = '0;
    for (int unsigned k = 0; k < NUM_RS; k++) begin
      if (!w_any && rs_valid_in[rr_idx(r_ptr, k)]) begin
        w_any = 1'b1;
        w_g   = rr_idx(r_ptr, k);
      end
    end
  end

  assign w_grant   = w_can_grant && w_any;
  assign w_dec     = fu_done_in && (r_occ != '0);
  assign w_ptr_nxt = (w_g == SRC_W'(NUM_RS - 1)) ? '0 : w_g + SRC_W'(1);

  always_comb begin
    w_busy = '1;
    for (int unsigned i = 0; i < NUM_RS; i++) begin
      w_busy[i] = !(w_grant && (w_g == SRC_W'(i)));
    end
  end

  assign w_rval1   = rs_rval1_in[32'(w_g)*DATA_W +: DATA_W];
  assign w_rval2   = rs_rval2_in[32'(w_g)*DATA_W +: DATA_W];
  assign w_opcode  = rs_opcode_in[32'(w_g)*OP_W +: OP_W];
  assign w_rob_idx = rs_rob_idx_in[32'(w_g)*ROB_W +: ROB_W];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_ptr      <= '0;
      r_occ      <= '0;
      r_fu_valid <= 1'b0;
      r_rval1    <= '0;
      r_rval2    <= '0;
      r_opcode   <= '0;
      r_rob_idx  <= '0;
      r_src      <= '0;
    end else if (flush_in) begin
      r_fu_valid <= 1'b0;
      r_occ      <= '0;
    end else begin
      if (w_grant) begin
        r_fu_valid <= 1'b1;
        r_rval1    <= w_rval1;
        r_rval2    <= w_rval2;
        r_opcode   <= w_opcode;
        r_rob_idx  <= w_rob_idx;
        r_src      <= w_g;
        r_ptr      <= w_ptr_nxt;
      end else if (fu_ready_in) begin
        r_fu_valid <= 1'b0;
      end
      if (w_grant && !w_dec) begin
        r_occ <= r_occ + CNT_W'(1);
      end else if (!w_grant && w_dec) begin
        r_occ <= r_occ - CNT_W'(1);
      end
    end
  end

`ifdef RS_ARB_STALL_CNT_EN
  logic [15:0] r_stall;

  // Counts cycles with a pending request but no grant; flush cycles are not counted.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_stall <= '0;
    end else if (!flush_in && (|rs_valid_in) && !w_grant && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign stall_cycles_out = r_stall;
`endif

  assign rs_fu_busy_out = w_busy;
  assign fu_valid_out   = r_fu_valid;
  assign fu_rval1_out   = r_rval1;
  assign fu_rval2_out   = r_rval2;
  assign fu_opcode_out  = r_opcode;
  assign fu_rob_idx_out = r_rob_idx;
  assign fu_src_out     = r_src;
  assign inflight_out   = r_occ;

endmodule

// File: doc/rs_issue_arbiter.md
# rs_issue_arbiter

Round-robin issue arbiter that shares one functional unit among `NUM_RS` reservation stations. It watches each station's output-valid and drives that station's `fu_busy_in`, releasing exactly one station per cycle when the FU has capacity. It latches the winning operands into a one-entry issue register toward the FU and tracks in-flight ops until the FU reports completion. It sits between the reservation stations and the FU/CDB stage.

## Interface
- `NUM_RS`, 4, number of reservation stations sharing the FU (2..8)
- `DATA_W`, 32, operand width
- `OP_W`, 4, opcode width
- `ROB_W`, 3, ROB index width
- `MAX_INFLIGHT`, 2, maximum ops granted but not yet completed (1..7)
- `clk_in` in 1: single clock, all state on rising edge
- `rst_in` in 1: synchronous, active-high reset
- `rs_valid_in` in `NUM_RS`: station i holds a ready op (its `rs_output_valid_out`)
- `rs_rval1_in`, `rs_rval2_in` in `NUM_RS*DATA_W`: operands, station i at bits [i*DATA_W +: DATA_W]
- `rs_opcode_in` in `NUM_RS*OP_W`: opcodes, same packing
- `rs_rob_idx_in` in `NUM_RS*ROB_W`: ROB indices, same packing
- `rs_fu_busy_out` out `NUM_RS`: to station i `fu_busy_in`; low only for the granted station
- `fu_ready_in` in 1: FU accepts the op in the issue register this cycle
- `fu_done_in` in 1: FU completes one op this cycle
- `flush_in` in 1: ROB flush, which discards queued and in-flight ops
- `fu_valid_out` out 1: issue register holds an op
- `fu_rval1_out`, `fu_rval2_out` out `DATA_W`: issued operands
- `fu_opcode_out` out `OP_W`, `fu_rob_idx_out` out `ROB_W`: issued opcode and ROB index
- `fu_src_out` out `$clog2(NUM_RS)`: index of the station that supplied the op
- `inflight_out` out `$clog2(MAX_INFLIGHT+1)`: occupancy count

## Operation
- `occ` counts ops granted and not yet done, including the one in the issue register.
- `can_grant = !rst_in && !flush_in && occ < MAX_INFLIGHT && (!fu_valid_out || fu_ready_in)`.
- Round-robin search runs from pointer `ptr` upward, modulo `NUM_RS`. The first i with `rs_valid_in[i]` wins as `g`.
- `rs_fu_busy_out[i] = !(can_grant && any valid && i == g)`. This output is combinational.
- On a grant edge:
  - The issue register loads station g's fields and sets `fu_valid_out=1`, `fu_src_out=g`.
  - `ptr <= (g+1) mod NUM_RS`.
  - The station dispatches on the same edge.
- Without a grant: if `fu_ready_in` is high, `fu_valid_out <= 0`. Otherwise the register holds and all outputs stay stable.
- `occ` update: +1 on grant, -1 on `fu_done_in`. Both in the same cycle leaves it unchanged. `fu_done_in` with `occ==0` is ignored (no underflow).
- `fu_done_in` in cycle t does not free capacity for a grant in cycle t. The freed slot is usable from t+1.
- Stations hold their fields stable while valid. The arbiter samples them only in the grant cycle.
- Flush: `fu_valid_out<=0` and `occ<=0`, no grant that cycle, `ptr` retained.
- Reset: `fu_valid_out=0`, all data outputs 0, `fu_src_out=0`, `occ=0`, `ptr=0`. `rs_fu_busy_out` is all ones while `rst_in` is high.
- Priority: reset > flush > grant/done.

## Timing
- Grant to issue latency is 1 cycle: valid at t with capacity gives `fu_valid_out` high at t+1.
- Throughput is one grant per cycle while `fu_ready_in` is high and `occ < MAX_INFLIGHT`.
- Backpressure: `fu_ready_in` low with `fu_valid_out` high blocks grants, and the register holds.
- Wrap: after granting station `NUM_RS-1`, the search starts at 0.
- Reset mid-operation: all state clears on that edge. Busy stays all-ones during the reset cycle, and a grant is possible from the first cycle after reset deasserts.

## Configuration
- Macro `RS_ARB_STALL_CNT_EN`.
- Defined: adds output `stall_cycles_out` (out, 16 bits).
  - Increments in each cycle where `|rs_valid_in` is high and no grant occurs, excluding reset and flush cycles.
  - Saturates at 16'hFFFF.
  - Resets to 0 on reset only; flush does not clear it.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

## Test plan
- Single request: station 2 valid with rval1=3, rval2=3, rob 5, occ 0 -> `rs_fu_busy_out=4'b1011`; next cycle `fu_valid_out=1`, rvals 3/3, rob 5, `fu_src_out=2`, `inflight_out=1`.
- Round-robin: stations 0, 1, 3 held valid, `fu_ready_in=1`, `fu_done_in=1` each cycle -> grant order 0, 1, 3, 0, 1, 3. `ptr` wraps after 3.
- Backpressure: `fu_ready_in=0` for 4 cycles with the register full -> all busy high, and the issue outputs stay unchanged. With the macro defined, `stall_cycles_out` rises by 4.
- Capacity: `MAX_INFLIGHT=2`, no done -> exactly two grants, then busy all high. `fu_done_in` pulse at t -> next grant at t+1, not t. Done and grant in the same cycle keep `inflight_out` unchanged.
- Flush: flush with occ=2 and the register valid -> next cycle `fu_valid_out=0`, `inflight_out=0`, no grant in the flush cycle. `ptr` is preserved, so the next grant continues round-robin order.
- Reset mid-operation: assert `rst_in` with occ=1 and requests pending -> busy all ones, and next cycle all outputs are at reset values. The first grant after reset goes to the lowest valid index.
